// File: rtl/graphics_scheduler_pkg.sv
// graphics_pkg: shared sizes and scheduler state encoding for the sprite mover.
package graphics_pkg;
  localparam int NUM_SLOTS = 4;
  localparam int TILE = 8;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, ACK} state_t;
endpackage

// File: rtl/graphics_scheduler_if.sv
// graphics_scheduler_if: requester bundle plus VGA plot port of the scheduler.
interface graphics_scheduler_if #(parameter int N = graphics_pkg::NUM_SLOTS);
  import graphics_pkg::*;
  logic [N-1:0] req;
  logic [N-1:0] ack;
  logic [XW*N-1:0] old_x;
  logic [YW*N-1:0] old_y;
  logic [XW*N-1:0] new_x;
  logic [YW*N-1:0] new_y;
  logic [CW*N-1:0] obj_colour;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  logic writeEn;
  logic busy;
  modport master (output req, old_x, old_y, new_x, new_y, obj_colour,
                  input ack, x, y, colour, writeEn, busy);
  modport slave (input req, old_x, old_y, new_x, new_y, obj_colour,
                 output ack, x, y, colour, writeEn, busy);
endinterface

// File: rtl/graphics_scheduler_tile_painter.sv
// tile_painter: raster-scans one TILE x TILE square from a reference origin with a fill colour.
module tile_painter
  import graphics_pkg::*;
#(
  parameter int TILE = graphics_pkg::TILE
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] ref_x,
  input  logic [YW-1:0] ref_y,
  input  logic [CW-1:0] fill,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour,
  output logic          writeEn,
  output logic          done
);
  localparam int OW = $clog2(TILE);
  localparam logic [2*OW-1:0] LAST = (2*OW)'(TILE*TILE-1);
  logic [2*OW-1:0] cnt;
  logic active;
  // start may coincide with done so two scans run back to back with no gap
  always_ff @(posedge clock) begin
    if (reset) begin
      active <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt <= '0;
    end else if (active) begin
      active <= cnt != LAST;
      cnt <= cnt + 1'b1;
    end
  end
  assign writeEn = active;
  assign done = active && cnt == LAST;
  assign x = active ? ref_x + XW'(cnt[OW-1:0]) : '0;
  assign y = active ? ref_y + YW'(cnt[2*OW-1:OW]) : '0;
  assign colour = active ? fill : '0;
endmodule

// File: rtl/graphics_scheduler.sv
// graphics_scheduler: round-robin grants sprite moves, clearing the old tile then drawing the new one.
module graphics_scheduler
  import graphics_pkg::*;
#(
  parameter int NUM_SLOTS = graphics_pkg::NUM_SLOTS,
  parameter int TILE = graphics_pkg::TILE
) (
  input logic clock,
  input logic reset,
  graphics_scheduler_if.slave bus
);
  localparam int SW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
  state_t state, nxt;
  logic [SW-1:0] ptr, grant, pick;
  logic [SW:0] s;
  logic [XW-1:0] ox, nx, ref_x;
  logic [YW-1:0] oy, ny, ref_y;
  logic [CW-1:0] col, fill;
  logic start, done;
  // walk downwards so the slot closest to the pointer is chosen last and wins
  always_comb begin
    pick = ptr;
    s = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      s = {1'b0, ptr} + (SW+1)'(i);
      if (s >= (SW+1)'(NUM_SLOTS)) s = s - (SW+1)'(NUM_SLOTS);
      if (bus.req[s[SW-1:0]]) pick = s[SW-1:0];
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      grant <= '0;
      ox <= '0;
      oy <= '0;
      nx <= '0;
      ny <= '0;
      col <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && |bus.req) begin
        grant <= pick;
        ox <= bus.old_x[int'(pick)*XW +: XW];
        oy <= bus.old_y[int'(pick)*YW +: YW];
        nx <= bus.new_x[int'(pick)*XW +: XW];
        ny <= bus.new_y[int'(pick)*YW +: YW];
        col <= bus.obj_colour[int'(pick)*CW +: CW];
      end
      if (state == ACK) ptr <= grant == SW'(NUM_SLOTS - 1) ? '0 : grant + 1'b1;
    end
  end
  always_comb begin
    nxt = state;
    start = 1'b0;
    case (state)
      IDLE: if (|bus.req) begin nxt = CLEAR; start = 1'b1; end
      CLEAR: if (done) begin nxt = DRAW; start = 1'b1; end
      DRAW: if (done) nxt = ACK;
      default: nxt = IDLE;
    endcase
  end
  assign ref_x = state == DRAW ? nx : ox;
  assign ref_y = state == DRAW ? ny : oy;
  assign fill = state == DRAW ? col : '0;
  assign bus.ack = state == ACK ? NUM_SLOTS'(1) << grant : '0;
  assign bus.busy = state != IDLE;
  tile_painter #(.TILE(TILE)) painter (
    .clock(clock),
    .reset(reset),
    .start(start),
    .ref_x(ref_x),
    .ref_y(ref_y),
    .fill(fill),
    .x(bus.x),
    .y(bus.y),
    .colour(bus.colour),
    .writeEn(bus.writeEn),
    .done(done)
  );
endmodule
